// File: rtl/glitc_ctrl_pkg.sv
// Shared address map, bit positions and DNA reader state type for the GLITC control block.
// Combinational helper only; no latency or backpressure of its own.
package glitc_ctrl_pkg;

    localparam logic [2:0] ADDR_IDENT          = 3'd0;
    localparam logic [2:0] ADDR_VERSION        = 3'd1;
    localparam logic [2:0] ADDR_CONTROL        = 3'd2;
    localparam logic [2:0] ADDR_REALIGN_STATUS = 3'd3;
    localparam logic [2:0] ADDR_DNA_LO         = 3'd4;
    localparam logic [2:0] ADDR_DNA_HI         = 3'd5;
    localparam logic [2:0] ADDR_SCRATCH        = 3'd6;
    localparam logic [2:0] ADDR_RSVD           = 3'd7;

    localparam int DNA_BITS      = 57;
    localparam int REALIGN_LSB   = 8;
    localparam int RESET_BIT     = 31;
    localparam int DNA_VALID_BIT = 31;
    localparam int DNA_BUSY_BIT  = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } dna_state_e;

    // Upper DNA word: status flags on top, DNA[56:32] in the low 25 bits.
    function automatic logic [31:0] dna_hi_word(input logic valid,
                                                input logic busy,
                                                input logic [DNA_BITS-1:0] dna);
        logic [31:0] w;
        w                  = '0;
        w[DNA_VALID_BIT]   = valid;
        w[DNA_BUSY_BIT]    = busy;
        w[DNA_BITS-33:0]   = dna[DNA_BITS-1:32];
        return w;
    endfunction

endpackage

// File: rtl/glitc_dna_reader.sv
// Reads the 57-bit device DNA once after reset and on request (only built with GLITC_DNA_READER_EN).
// 1 LOAD + 57 SHIFT cycles per read; start_i is ignored while a read is in flight.
`ifdef GLITC_DNA_READER_EN
module glitc_dna_reader
    import glitc_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [DNA_BITS-1:0] dna_o
);

    dna_state_e          state_q;
    dna_state_e          state_d;
    logic                boot_q;
    logic [5:0]          cnt_q;
    logic [DNA_BITS-1:0] dna_q;
    logic                valid_q;
    logic                dna_read;
    logic                dna_shift;
    logic                dna_dout;

    DNA_PORT u_dna_port (
        .DOUT  (dna_dout),
        .CLK   (clk),
        .DIN   (1'b0),
        .READ  (dna_read),
        .SHIFT (dna_shift)
    );

    // boot_q requests the automatic read on the first cycle out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == LOAD)
                boot_q <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        dna_read  = 1'b0;
        dna_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (boot_q || start_i)
                    state_d = LOAD;
            end
            LOAD: begin
                dna_read = 1'b1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                dna_shift = 1'b1;
                if (cnt_q == 6'(DNA_BITS - 1))
                    state_d = DONE;
            end
            DONE: begin
                state_d = start_i ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            dna_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (state_q == LOAD)
                cnt_q <= '0;
            else if (state_q == SHIFT && cnt_q != 6'(DNA_BITS - 1))
                cnt_q <= cnt_q + 6'd1;

            // DOUT presents the MSB first, so shift captured bits up from the bottom.
            if (state_q == SHIFT)
                dna_q <= {dna_q[DNA_BITS-2:0], dna_dout};

            if (state_d == LOAD && state_q != LOAD)
                valid_q <= 1'b0;
            else if (state_q == SHIFT && state_d == DONE)
                valid_q <= 1'b1;
        end
    end

    assign busy_o  = (state_q == LOAD) || (state_q == SHIFT);
    assign valid_o = valid_q;
    assign dna_o   = dna_q;

endmodule
`endif

// File: rtl/glitc_ctrl_regfile.sv
// GLITC control register file: ident/version, clock control, realign pulses, reset stretcher, scratch, optional DNA (GLITC_DNA_READER_EN).
// Writes take effect on the clock edge, reads are combinational; no backpressure.
module glitc_ctrl_regfile
    import glitc_ctrl_pkg::*;
#(
    parameter logic [31:0] IDENT              = "GLTC",
    parameter logic [31:0] VERSION            = 32'h00000000,
    parameter int          NUM_CHANNELS       = 4,
    parameter int          CLK_CTRL_BITS      = 3,
    parameter int          RESET_PULSE_CYCLES = 16
) (
    input  logic                     user_clk_i,
    input  logic                     user_rst_i,
    input  logic [2:0]               user_addr_i,
    input  logic [31:0]              user_dat_i,
    output logic [31:0]              user_dat_o,
    input  logic                     user_wr_i,
    input  logic                     user_rd_i,
    input  logic                     user_sel_i,
    output logic [NUM_CHANNELS-1:0]  realign_o,
    input  logic [NUM_CHANNELS-1:0]  realigned_i,
    output logic [CLK_CTRL_BITS-1:0] clk_control_o,
    output logic                     reset_o
);

    logic                      wr_en;
    logic                      ctrl_wr;
    logic [CLK_CTRL_BITS-1:0]  clk_ctrl_q;
    logic [NUM_CHANNELS-1:0]   realign_q;
    logic [NUM_CHANNELS-1:0]   status_q;
    logic [7:0]                rst_cnt_q;
    logic [31:0]               scratch_q;
    logic [31:0]               rd_dat;
    logic                      dna_busy;
    logic                      dna_valid;
    logic [DNA_BITS-1:0]       dna_val;
    logic                      unused_ok;

    assign wr_en   = user_sel_i & user_wr_i;
    assign ctrl_wr = wr_en && (user_addr_i == ADDR_CONTROL);

`ifdef GLITC_DNA_READER_EN
    logic dna_start;

    assign dna_start = wr_en && (user_addr_i == ADDR_DNA_HI) && user_dat_i[DNA_VALID_BIT];

    glitc_dna_reader u_dna_reader (
        .clk     (user_clk_i),
        .rst     (user_rst_i),
        .start_i (dna_start),
        .busy_o  (dna_busy),
        .valid_o (dna_valid),
        .dna_o   (dna_val)
    );
`else
    assign dna_busy  = 1'b0;
    assign dna_valid = 1'b0;
    assign dna_val   = '0;
`endif

    // Reads are decoded from the address alone; the read strobe carries no side effects.
    assign unused_ok = &{1'b0, user_rd_i};

    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            clk_ctrl_q <= '0;
            realign_q  <= '0;
            status_q   <= '0;
            rst_cnt_q  <= '0;
            scratch_q  <= '0;
        end else begin
            if (ctrl_wr)
                clk_ctrl_q <= user_dat_i[CLK_CTRL_BITS-1:0];

            realign_q <= ctrl_wr ? user_dat_i[REALIGN_LSB +: NUM_CHANNELS] : '0;

            // A done pulse in the same cycle as the realign pulse keeps the bit set.
            status_q <= (status_q & ~realign_q) | realigned_i;

            if (ctrl_wr && user_dat_i[RESET_BIT])
                rst_cnt_q <= 8'(RESET_PULSE_CYCLES);
            else if (rst_cnt_q != 8'd0)
                rst_cnt_q <= rst_cnt_q - 8'd1;

            if (wr_en && (user_addr_i == ADDR_SCRATCH))
                scratch_q <= user_dat_i;
        end
    end

    always_comb begin
        rd_dat = '0;
        case (user_addr_i)
            ADDR_IDENT:          rd_dat = IDENT;
            ADDR_VERSION:        rd_dat = VERSION;
            ADDR_CONTROL:        rd_dat[CLK_CTRL_BITS-1:0] = clk_ctrl_q;
            ADDR_REALIGN_STATUS: rd_dat[NUM_CHANNELS-1:0] = status_q;
            ADDR_DNA_LO:         rd_dat = dna_val[31:0];
            ADDR_DNA_HI:         rd_dat = dna_hi_word(dna_valid, dna_busy, dna_val);
            ADDR_SCRATCH:        rd_dat = scratch_q;
            ADDR_RSVD:           rd_dat = '0;
            default:             rd_dat = '0;
        endcase
    end

    assign user_dat_o    = rd_dat;
    assign realign_o     = realign_q;
    assign clk_control_o = clk_ctrl_q;
    assign reset_o       = (rst_cnt_q != 8'd0);

endmodule
